// File: rtl/decode_stage.sv
// RV32I decode stage: reg_file read addressing, writeback bypass, immediate
// generation, load-use detection and a valid/ready output register to execute.
module decode_stage #(
    parameter int          XLEN      = 32,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    // fetch side
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc,
    input  logic            flush,
    // reg_file read ports
    output logic [4:0]      rg_sr1_addr,
    output logic [4:0]      rg_sr2_addr,
    input  logic [XLEN-1:0] rg_sr1_data,
    input  logic [XLEN-1:0] rg_sr2_data,
    // writeback bypass
    input  logic            wb_write_en,
    input  logic [4:0]      wb_des_addr,
    input  logic [XLEN-1:0] wb_des_data,
    // execute side
    input  logic            ex_ready,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [31:0]     id_instr,
    output logic [XLEN-1:0] id_rs1_val,
    output logic [XLEN-1:0] id_rs2_val,
    output logic [XLEN-1:0] id_imm,
    output logic [4:0]      id_rs1,
    output logic [4:0]      id_rs2,
    output logic [4:0]      id_rd,
    output logic            id_reg_write,
    output logic            id_mem_read,
    output logic            id_mem_write,
    output logic            id_branch,
    output logic            id_jump,
    output logic            id_illegal
);

    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_REG    = 7'h33;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_SYSTEM = 7'h73;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic [XLEN-1:0] rs1_val;
        logic [XLEN-1:0] rs2_val;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            branch;
        logic            jump;
        logic            illegal;
    } id_bundle_t;

    // ---------------- field extraction ----------------
    logic [6:0]  opcode;
    logic [4:0]  rs1_field, rs2_field, rd_field;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode    = if_instr[6:0];
    assign rs1_field = if_instr[19:15];
    assign rs2_field = if_instr[24:20];
    assign rd_field  = if_instr[11:7];

    // reg_file is addressed straight from the raw fields; unused-field
    // masking happens only on the decoded bundle.
    assign rg_sr1_addr = rs1_field;
    assign rg_sr2_addr = rs2_field;

    assign imm_i = {{20{if_instr[31]}}, if_instr[31:20]};
    assign imm_s = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
    assign imm_b = {{19{if_instr[31]}}, if_instr[31], if_instr[7],
                    if_instr[30:25], if_instr[11:8], 1'b0};
    assign imm_u = {if_instr[31:12], 12'b0};
    assign imm_j = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12],
                    if_instr[20], if_instr[30:21], 1'b0};

    // ---------------- format decode ----------------
    logic        use_rs1, use_rs2, use_rd;
    logic [31:0] dec_imm;
    logic        dec_mem_read, dec_mem_write, dec_branch, dec_jump, dec_illegal;
    logic        dec_reg_write;

    // Classify the opcode: which register fields matter, which immediate, which flags.
    always_comb begin
        use_rs1       = 1'b0;
        use_rs2       = 1'b0;
        use_rd        = 1'b0;
        dec_imm       = '0;
        dec_mem_read  = 1'b0;
        dec_mem_write = 1'b0;
        dec_branch    = 1'b0;
        dec_jump      = 1'b0;
        dec_illegal   = 1'b0;
        case (opcode)
            OP_LOAD:   begin use_rs1 = 1'b1; use_rd = 1'b1; dec_imm = imm_i; dec_mem_read = 1'b1; end
            OP_IMM:    begin use_rs1 = 1'b1; use_rd = 1'b1; dec_imm = imm_i; end
            OP_JALR:   begin use_rs1 = 1'b1; use_rd = 1'b1; dec_imm = imm_i; dec_jump = 1'b1; end
            OP_STORE:  begin use_rs1 = 1'b1; use_rs2 = 1'b1; dec_imm = imm_s; dec_mem_write = 1'b1; end
            OP_BRANCH: begin use_rs1 = 1'b1; use_rs2 = 1'b1; dec_imm = imm_b; dec_branch = 1'b1; end
            OP_LUI,
            OP_AUIPC:  begin use_rd = 1'b1; dec_imm = imm_u; end
            OP_JAL:    begin use_rd = 1'b1; dec_imm = imm_j; dec_jump = 1'b1; end
            OP_REG:    begin use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1; end
            OP_SYSTEM: ;
            default:   dec_illegal = 1'b1;
        endcase
        // Compressed-looking encodings are not supported: treat as illegal.
        if (if_instr[1:0] != 2'b11) begin
            use_rs1       = 1'b0;
            use_rs2       = 1'b0;
            use_rd        = 1'b0;
            dec_imm       = '0;
            dec_mem_read  = 1'b0;
            dec_mem_write = 1'b0;
            dec_branch    = 1'b0;
            dec_jump      = 1'b0;
            dec_illegal   = 1'b1;
        end
    end

    // Writes to x0 are architecturally discarded, so never flag them.
    assign dec_reg_write = use_rd && (rd_field != 5'd0);

    // ---------------- operands with writeback bypass ----------------
    logic [4:0]      src1_idx, src2_idx, dst_idx;
    logic [XLEN-1:0] src1_val, src2_val;

    // Select operand values: x0 is zero, a same-cycle writeback beats the reg_file read.
    always_comb begin
        src1_idx = use_rs1 ? rs1_field : 5'd0;
        src2_idx = use_rs2 ? rs2_field : 5'd0;
        dst_idx  = use_rd  ? rd_field  : 5'd0;
        if (src1_idx == 5'd0)
            src1_val = '0;
        else if (wb_write_en && (wb_des_addr == src1_idx))
            src1_val = wb_des_data;
        else
            src1_val = rg_sr1_data;
        if (src2_idx == 5'd0)
            src2_val = '0;
        else if (wb_write_en && (wb_des_addr == src2_idx))
            src2_val = wb_des_data;
        else
            src2_val = rg_sr2_data;
    end

    // ---------------- output stage and handshake ----------------
    id_bundle_t bundle_q, bundle_d;
    logic       valid_q, valid_d;
    logic       flush_hold_q, flush_hold_d;
    logic       room, load_use;
    id_bundle_t dec_bundle, bubble;

    // Assemble the decoded bundle for the incoming instruction and the empty one.
    always_comb begin
        dec_bundle           = '0;
        dec_bundle.pc        = if_pc;
        dec_bundle.instr     = if_instr;
        dec_bundle.rs1_val   = src1_val;
        dec_bundle.rs2_val   = src2_val;
        dec_bundle.imm       = dec_imm;
        dec_bundle.rs1       = src1_idx;
        dec_bundle.rs2       = src2_idx;
        dec_bundle.rd        = dst_idx;
        dec_bundle.reg_write = dec_reg_write;
        dec_bundle.mem_read  = dec_mem_read;
        dec_bundle.mem_write = dec_mem_write;
        dec_bundle.branch    = dec_branch;
        dec_bundle.jump      = dec_jump;
        dec_bundle.illegal   = dec_illegal;
        bubble               = '0;
        bubble.instr         = NOP_INSTR;
    end

    // Handshake and next-state priority: flush, load-use bubble, accept, drain, hold.
    always_comb begin
        room     = !valid_q || ex_ready;
        // A load in the output register whose rd feeds a live source of the
        // incoming instruction cannot be bypassed yet: hold fetch one cycle.
        load_use = valid_q && bundle_q.mem_read && (bundle_q.rd != 5'd0) && if_valid &&
                   ((use_rs1 && (rs1_field == bundle_q.rd)) ||
                    (use_rs2 && (rs2_field == bundle_q.rd)));
        // During flush fetch is drained so the redirected-away instruction is consumed.
        if_ready = rst && (flush || (!flush_hold_q && room && !load_use));

        valid_d      = valid_q;
        bundle_d     = bundle_q;
        flush_hold_d = 1'b0;
        if (flush) begin
            valid_d  = 1'b0;
            bundle_d = bubble;
        end else if (load_use && room) begin
            valid_d  = 1'b0;
            bundle_d = bubble;
        end else if (if_valid && if_ready) begin
            valid_d  = 1'b1;
            bundle_d = dec_bundle;
        end else if (room) begin
            valid_d  = 1'b0;
            bundle_d = bubble;
        end
    end

    // Output register; intake stays closed for the first cycle out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q       <= 1'b0;
            bundle_q      <= '0;
            bundle_q.instr <= NOP_INSTR;
            flush_hold_q  <= 1'b1;
        end else begin
            valid_q      <= valid_d;
            bundle_q     <= bundle_d;
            flush_hold_q <= flush_hold_d;
        end
    end

    assign id_valid     = valid_q;
    assign id_pc        = bundle_q.pc;
    assign id_instr     = bundle_q.instr;
    assign id_rs1_val   = bundle_q.rs1_val;
    assign id_rs2_val   = bundle_q.rs2_val;
    assign id_imm       = bundle_q.imm;
    assign id_rs1       = bundle_q.rs1;
    assign id_rs2       = bundle_q.rs2;
    assign id_rd        = bundle_q.rd;
    assign id_reg_write = bundle_q.reg_write;
    assign id_mem_read  = bundle_q.mem_read;
    assign id_mem_write = bundle_q.mem_write;
    assign id_branch    = bundle_q.branch;
    assign id_jump      = bundle_q.jump;
    assign id_illegal   = bundle_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: the driver pushes hand-computed bundles,
// a monitor pops and compares each bundle execute consumes.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid, if_ready, flush;
    logic [31:0] if_instr, if_pc;
    logic [4:0]  rg_sr1_addr, rg_sr2_addr;
    logic [31:0] rg_sr1_data, rg_sr2_data;
    logic        wb_write_en;
    logic [4:0]  wb_des_addr;
    logic [31:0] wb_des_data;
    logic        ex_ready, id_valid;
    logic [31:0] id_pc, id_instr, id_rs1_val, id_rs2_val, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_reg_write, id_mem_read, id_mem_write, id_branch, id_jump, id_illegal;

    always #5 clk = ~clk;

    // static reg_file model with combinational reads
    logic [31:0] regs [0:31];
    assign rg_sr1_data = regs[rg_sr1_addr];
    assign rg_sr2_data = regs[rg_sr2_addr];

    decode_stage dut (
        .clk(clk), .rst(rst),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
        .flush(flush),
        .rg_sr1_addr(rg_sr1_addr), .rg_sr2_addr(rg_sr2_addr),
        .rg_sr1_data(rg_sr1_data), .rg_sr2_data(rg_sr2_data),
        .wb_write_en(wb_write_en), .wb_des_addr(wb_des_addr), .wb_des_data(wb_des_data),
        .ex_ready(ex_ready), .id_valid(id_valid),
        .id_pc(id_pc), .id_instr(id_instr), .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val),
        .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_branch(id_branch), .id_jump(id_jump), .id_illegal(id_illegal)
    );

    // flags packed as {reg_write, mem_read, mem_write, branch, jump, illegal}
    typedef struct packed {
        logic [31:0] pc, instr, rs1v, rs2v, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [5:0]  flags;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] pc, instr, rs1v, rs2v, imm,
                                input logic [4:0] rs1, rs2, rd, input logic [5:0] flags);
        exp_t e;
        e.pc = pc; e.instr = instr; e.rs1v = rs1v; e.rs2v = rs2v; e.imm = imm;
        e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.flags = flags;
        return e;
    endfunction

    // monitor: every bundle consumed by execute must match the scoreboard head
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && id_valid && ex_ready) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_bundle: got pc %h instr %h expected none", id_pc, id_instr);
                end else begin
                    e = sb.pop_front();
                    chk("id_pc", id_pc, e.pc);
                    chk("id_instr", id_instr, e.instr);
                    chk("id_rs1_val", id_rs1_val, e.rs1v);
                    chk("id_rs2_val", id_rs2_val, e.rs2v);
                    chk("id_imm", id_imm, e.imm);
                    chk("id_rs_rd", {17'd0, id_rs1, id_rs2, id_rd}, {17'd0, e.rs1, e.rs2, e.rd});
                    chk("id_flags", {26'd0, id_reg_write, id_mem_read, id_mem_write,
                                     id_branch, id_jump, id_illegal}, {26'd0, e.flags});
                end
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    // present an instruction until accepted; called just after a rising edge
    task automatic issue(input logic [31:0] instr, input logic [31:0] pc, input exp_t e,
                         output int stalls);
        stalls   = 0;
        if_valid = 1'b1; if_instr = instr; if_pc = pc;
        @(negedge clk);
        while (!if_ready && stalls < 20) begin
            stalls++;
            @(negedge clk);
        end
        if (!if_ready) begin
            checks++; errors++;
            $display("FAIL issue_timeout: got if_ready 0 for pc %h expected 1", pc);
        end else begin
            sb.push_back(e);
        end
        @(posedge clk); #1;
        if_valid = 1'b0;
    endtask

    localparam logic [31:0] ADDI = 32'hFFF00293;
    localparam logic [31:0] BEQ  = 32'hFE208EE3;
    localparam logic [31:0] ADD  = 32'h001101B3;
    localparam logic [31:0] LW   = 32'h0000A103;
    localparam logic [31:0] SW   = 32'h0020A223;
    localparam logic [31:0] JAL  = 32'h008000EF;
    localparam logic [31:0] LUI  = 32'h123453B7;
    localparam logic [31:0] ADDI1 = 32'h00100093;

    initial begin
        int st;
        for (int i = 0; i < 32; i++) regs[i] = 32'h0;
        regs[1] = 32'h11111111;
        regs[2] = 32'h22222222;
        rst = 1'b0; flush = 1'b0; ex_ready = 1'b1;
        if_valid = 1'b1; if_instr = ADDI; if_pc = 32'h40;
        wb_write_en = 1'b0; wb_des_addr = 5'd0; wb_des_data = 32'h0;

        // reset held for two cycles with fetch presenting
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
            chk("rst_if_ready", {31'd0, if_ready}, 32'd0);
            chk("rst_id_instr", id_instr, 32'h00000013);
        end
        chk("rst_id_pc", id_pc, 32'd0);
        chk("rst_id_fields", {id_imm[25:0], id_rd, id_reg_write}, 32'd0);
        step();
        rst = 1'b1; if_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_if_ready", {31'd0, if_ready}, 32'd1);
        chk("post_rst_id_valid", {31'd0, id_valid}, 32'd0);
        step();

        // ALU and branch decode
        issue(ADDI, 32'h100, mk(32'h100, ADDI, 0, 0, 32'hFFFFFFFF, 0, 0, 5, 6'b100000), st);
        if_instr = BEQ; #1;
        chk("beq_rg_sr1_addr", {27'd0, rg_sr1_addr}, 32'd1);
        chk("beq_rg_sr2_addr", {27'd0, rg_sr2_addr}, 32'd2);
        issue(BEQ, 32'h104, mk(32'h104, BEQ, 32'h11111111, 32'h22222222, 32'hFFFFFFFC,
                               1, 2, 0, 6'b000100), st);

        // bypass of a same-cycle writeback to rs2, then x0 writeback ignored
        wb_write_en = 1'b1; wb_des_addr = 5'd1; wb_des_data = 32'hDEADBEEF;
        issue(ADD, 32'h108, mk(32'h108, ADD, 32'h22222222, 32'hDEADBEEF, 0, 2, 1, 3, 6'b100000), st);
        wb_des_addr = 5'd0;
        issue(ADD, 32'h10C, mk(32'h10C, ADD, 32'h22222222, 32'h11111111, 0, 2, 1, 3, 6'b100000), st);
        wb_write_en = 1'b0;

        // load-use: exactly one bubble; unrelated follower has none
        issue(LW, 32'h110, mk(32'h110, LW, 32'h11111111, 0, 0, 1, 0, 2, 6'b110000), st);
        issue(ADD, 32'h114, mk(32'h114, ADD, 32'h22222222, 32'h11111111, 0, 2, 1, 3, 6'b100000), st);
        chk("load_use_stalls", st, 32'd1);
        issue(LW, 32'h118, mk(32'h118, LW, 32'h11111111, 0, 0, 1, 0, 2, 6'b110000), st);
        issue(ADDI, 32'h11C, mk(32'h11C, ADDI, 0, 0, 32'hFFFFFFFF, 0, 0, 5, 6'b100000), st);
        chk("no_hazard_stalls", st, 32'd0);

        // remaining formats and illegal encodings
        issue(SW, 32'h120, mk(32'h120, SW, 32'h11111111, 32'h22222222, 32'd4, 1, 2, 0, 6'b001000), st);
        issue(JAL, 32'h124, mk(32'h124, JAL, 0, 0, 32'd8, 0, 0, 1, 6'b100010), st);
        issue(LUI, 32'h128, mk(32'h128, LUI, 0, 0, 32'h12345000, 0, 0, 7, 6'b100000), st);
        issue(32'hFFFFFFFF, 32'h12C, mk(32'h12C, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 6'b000001), st);
        issue(32'h00000000, 32'h130, mk(32'h130, 32'h00000000, 0, 0, 0, 0, 0, 0, 6'b000001), st);
        step(); step();

        // backpressure: bundle held stable, fetch blocked
        ex_ready = 1'b0;
        issue(ADDI1, 32'h200, mk(32'h200, ADDI1, 0, 0, 32'd1, 0, 0, 1, 6'b100000), st);
        if_valid = 1'b1; if_instr = LUI; if_pc = 32'h204;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_id_valid", {31'd0, id_valid}, 32'd1);
            chk("bp_id_pc", id_pc, 32'h200);
            chk("bp_id_instr", id_instr, ADDI1);
            chk("bp_if_ready", {31'd0, if_ready}, 32'd0);
        end
        // flush while stalled: held bundle and presented instruction both dropped
        step();
        flush = 1'b1;
        @(negedge clk);
        chk("flush_if_ready", {31'd0, if_ready}, 32'd1);
        if (sb.size() > 0) void'(sb.pop_back());
        step();
        flush = 1'b0; if_valid = 1'b0; ex_ready = 1'b1;
        @(negedge clk);
        chk("flush_id_valid", {31'd0, id_valid}, 32'd0);
        chk("flush_id_instr", id_instr, 32'h00000013);
        chk("flush_id_pc", id_pc, 32'd0);
        step(); step(); step();

        // pipeline alive after flush
        issue(LUI, 32'h300, mk(32'h300, LUI, 0, 0, 32'h12345000, 0, 0, 7, 6'b100000), st);
        step(); step(); step();
        chk("scoreboard_empty", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
